// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit:
// condition encodings, flag bit positions and flag-write selects.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction's
// condition field passes against the stored NZCV flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass,
    output logic       undef
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond_e'(cond))
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

    assign undef = (cond == COND_NV);

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV register, write-strobe gating,
// sticky undefined-condition flag and executed/squashed counters.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             InstrValid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             CntClr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic             UndefCond,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SquashCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic pass;
    logic undef;

    cond_check u_check (
        .cond  (Cond),
        .flags (Flags),
        .pass  (pass),
        .undef (undef)
    );

    assign CondEx   = InstrValid & pass;
    assign PCSrc    = PCS & CondEx;
    assign RegWrite = RegW & CondEx & ~NoWrite;
    assign MemWrite = MemW & CondEx;

    always_ff @(posedge clk) begin
        if (reset) begin
            Flags       <= 4'b0000;
            UndefCond   <= 1'b0;
            ExecCount   <= '0;
            SquashCount <= '0;
        end else begin
            if (CondEx && FlagW[FW_NZ]) begin
                Flags[FLAG_N] <= ALUFlags[FLAG_N];
                Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (CondEx && FlagW[FW_CV]) begin
                Flags[FLAG_C] <= ALUFlags[FLAG_C];
                Flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
            if (InstrValid && undef)
                UndefCond <= 1'b1;
            // A clear wins over the increment of the same cycle
            if (CntClr) begin
                ExecCount   <= '0;
                SquashCount <= '0;
            end else if (InstrValid) begin
                if (CondEx) begin
                    if (ExecCount != CNT_MAX)
                        ExecCount <= ExecCount + CNT_W'(1);
                end else if (SquashCount != CNT_MAX) begin
                    SquashCount <= SquashCount + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit of the ARM single-cycle datapath, directly downstream of the ALU. It holds the architectural NZCV flags register and consumes the ALU's 4-bit flag vector. It evaluates each instruction's 4-bit condition field against the stored flags and gates the decoder's PC, register and memory write strobes. It also keeps sticky/statistics state (undefined-condition flag, executed/squashed counters) for debug.

## Interface
- CNT_W, default 32: width of the executed and squashed instruction counters.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- InstrValid  in  1  current instruction is real; when low it is treated as a bubble.
- Cond  in  4  instruction condition field, Instr[31:28].
- ALUFlags  in  4  ALU result flags, {N,Z,C,V} = bits [3:0].
- FlagW  in  2  decoder flag-write request; [1] selects N,Z and [0] selects C,V.
- PCS  in  1  decoder PC-write request.
- RegW  in  1  decoder register-write request.
- MemW  in  1  decoder memory-write request.
- NoWrite  in  1  decoder suppresses the register write (CMP/CMN/TST/TEQ).
- CntClr  in  1  synchronous clear of both counters.
- PCSrc  out  1  gated PCS.
- RegWrite  out  1  gated RegW.
- MemWrite  out  1  gated MemW.
- CondEx  out  1  the condition passed for a valid instruction.
- Flags  out  4  registered {N,Z,C,V}.
- UndefCond  out  1  sticky flag: a valid instruction carried Cond = 4'b1111.
- ExecCount  out  CNT_W  number of valid instructions with CondEx = 1.
- SquashCount  out  CNT_W  number of valid instructions with CondEx = 0.

## Operation
- Condition check is combinational on the registered Flags, never on the ALUFlags of the same cycle:
  - EQ 0000: Z. NE 0001: !Z.
  - CS 0010: C. CC 0011: !C.
  - MI 0100: N. PL 0101: !N.
  - VS 0110: V. VC 0111: !V.
  - HI 1000: C & !Z. LS 1001: !C | Z.
  - GE 1010: N == V. LT 1011: N != V.
  - GT 1100: !Z & (N == V). LE 1101: Z | (N != V).
  - AL 1110: 1.
  - 1111: 0, and the instruction is counted as squashed.
- CondEx = InstrValid & condition pass.
- Strobe gating:
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & CondEx & !NoWrite.
  - MemWrite = MemW & CondEx.
- Flag write:
  - If CondEx and FlagW[1] are set, N and Z load ALUFlags[3:2] at the edge.
  - If CondEx and FlagW[0] are set, C and V load ALUFlags[1:0] at the edge.
  - Each half is otherwise held independently.
- UndefCond is set when InstrValid = 1 and Cond = 1111. Only reset clears it.
- Counters:
  - On InstrValid, exactly one counter increments: ExecCount if CondEx, else SquashCount.
  - Both counters saturate at all-ones and do not wrap.
  - With InstrValid = 0 neither counter changes, flags hold, and all strobes are 0.
- Priority: reset > CntClr > increment. CntClr together with a valid instruction leaves both counters at 0 (the increment is lost). CntClr does not affect Flags or UndefCond.

## Timing
- Reset values: Flags = 4'b0000, UndefCond = 0, ExecCount = 0, SquashCount = 0.
- The gated strobes and CondEx are purely combinational. During reset they still follow their inputs; the core holds InstrValid low during reset.
- Latency:
  - Flags, UndefCond and the counters update one edge after the qualifying cycle.
  - An instruction sees flags written by the previous instruction, with zero bubbles.
- An instruction whose condition fails and which has FlagW ≠ 0 does not write flags. Its own comparison uses the pre-edge flags.
- Reset asserted mid-stream discards any flag write of that cycle. The first valid instruction after reset sees NZCV = 0000, so EQ fails and NE passes.

## Structure
- Shared package cond_pkg:
  - cond_e enum of the 16 condition encodings.
  - Flag bit-index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - FlagW bit constants FW_NZ = 1, FW_CV = 0.
- Sub-module cond_check: combinational, (Cond, Flags) -> pass, undef. It is instantiated once.
- The top level holds the flags register, sticky bit, counters and gating.

## Test plan
- Reset, then a valid AL instruction with RegW = 1 and FlagW = 11, ALUFlags = 0100 -> RegWrite = 1 in that cycle; Flags = 0100 next cycle; ExecCount = 1.
- Flags = 0100, then BNE (Cond = 0001, PCS = 1) -> PCSrc = 0, CondEx = 0, SquashCount increments. Then BEQ -> PCSrc = 1.
- CMP with FlagW = 11, NoWrite = 1, RegW = 1, ALUFlags = 0010 -> RegWrite = 0, Flags = 0010. Then HI (1000) -> passes; LS (1001) -> fails.
- Partial write: Flags = 1111, then AL with FlagW = 10 and ALUFlags = 0000 -> Flags = 0011.
- Cond = 1111 valid with MemW = 1 -> MemWrite = 0, UndefCond = 1 and sticky. CntClr in that same cycle -> both counters 0, UndefCond stays 1.
- CNT_W = 4: 17 consecutive valid AL instructions -> ExecCount stops at 15. InstrValid = 0 with PCS = 1 -> PCSrc = 0 and no counter change.
